// File: rtl/accel_core_pkg.sv
// Shared types for the accelerator job controller: FSM states and error codes.
package accel_core_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_ZERO_LEN = 2'd1,
    ERR_ABORT    = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } err_code_t;

  function automatic logic is_active(state_t s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/accel_job_wdog.sv
// Stall watchdog: counts consecutive active cycles without a beat and flags
// expiry on the TIMEOUT_CYCLES-th one.
module accel_job_wdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic active,
  input  logic kick,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT_CYCLES + 1);

  logic [W-1:0] idle_q;

  assign expired = active && !kick && (idle_q == W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      idle_q <= '0;
    end else if (!active || kick) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + W'(1);
    end
  end

endmodule

// File: rtl/accel_job_ctrl.sv
// Job controller moving cfg_len beats from input buffer through the core into
// the output buffer. Define ACCEL_JOB_CTRL_TIMEOUT_EN to add the stall watchdog.
module accel_job_ctrl
  import accel_core_pkg::*;
#(
  parameter int CNT_WIDTH      = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 cfg_start,
  input  logic                 cfg_abort,
  input  logic [CNT_WIDTH-1:0] cfg_len,
  input  logic                 input_buff_empty,
  input  logic                 output_buff_full,
  output logic                 in_rd_en,
  output logic                 core_in_valid,
  input  logic                 core_in_ready,
  input  logic                 core_out_valid,
  output logic                 core_out_ready,
  output logic                 out_wr_en,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic                 irq
);

  state_t               state_q, state_d;
  err_code_t            err_code_q, err_code_d;
  logic [CNT_WIDTH-1:0] len_q, in_cnt_q, out_cnt_q, in_cnt_nx, out_cnt_nx;
  logic                 done_q, err_q, irq_q, core_in_valid_q;
  logic                 active, start_ok, wdog_expired;

  assign active     = is_active(state_q);
  assign start_ok   = (state_q == ST_IDLE) && cfg_start;
  assign in_cnt_nx  = in_cnt_q + CNT_WIDTH'(in_rd_en);
  assign out_cnt_nx = out_cnt_q + CNT_WIDTH'(out_wr_en);

`ifdef ACCEL_JOB_CTRL_TIMEOUT_EN
  accel_job_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .aclk    (aclk),
    .aresetn (aresetn),
    .active  (active),
    .kick    (in_rd_en || out_wr_en),
    .expired (wdog_expired)
  );
`else
  logic unused_timeout;
  assign wdog_expired   = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Abort outranks timeout, which outranks completion in the same cycle.
  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          if (cfg_len == '0) begin
            state_d    = ST_ERR;
            err_code_d = ERR_ZERO_LEN;
          end else begin
            state_d    = ST_RUN;
            err_code_d = ERR_NONE;
          end
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (cfg_abort) begin
          state_d    = ST_ERR;
          err_code_d = ERR_ABORT;
        end else if (wdog_expired) begin
          state_d    = ST_ERR;
          err_code_d = ERR_TIMEOUT;
        end else if ((in_cnt_nx == len_q) && (out_cnt_nx == len_q)) begin
          state_d = ST_DONE;
        end else if ((state_q == ST_RUN) && (in_cnt_nx == len_q)) begin
          state_d = ST_DRAIN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy           = active;
    in_rd_en       = (state_q == ST_RUN) && !input_buff_empty && core_in_ready &&
                     (in_cnt_q < len_q);
    core_out_ready = active && !output_buff_full && (out_cnt_q < len_q);
    out_wr_en      = core_out_valid && core_out_ready;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      len_q           <= '0;
      in_cnt_q        <= '0;
      out_cnt_q       <= '0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
      irq_q           <= 1'b0;
      core_in_valid_q <= 1'b0;
      err_code_q      <= ERR_NONE;
    end else begin
      core_in_valid_q <= in_rd_en;
      err_code_q      <= err_code_d;
      irq_q           <= (state_d == ST_DONE) || (state_d == ST_ERR);
      if (start_ok) begin
        len_q     <= cfg_len;
        in_cnt_q  <= '0;
        out_cnt_q <= '0;
        done_q    <= 1'b0;
        err_q     <= (cfg_len == '0);
      end else begin
        in_cnt_q  <= in_cnt_nx;
        out_cnt_q <= out_cnt_nx;
        if (state_d == ST_DONE) done_q <= 1'b1;
        if (state_d == ST_ERR)  err_q  <= 1'b1;
      end
    end
  end

  assign core_in_valid = core_in_valid_q;
  assign done          = done_q;
  assign err           = err_q;
  assign err_code      = err_code_q;
  assign irq           = irq_q;

endmodule

// File: tb/tb_accel_job_ctrl.sv
// Randomized self-checking bench for accel_job_ctrl against a job-level model;
// the timeout scenario runs only when ACCEL_JOB_CTRL_TIMEOUT_EN is defined.
module tb_accel_job_ctrl;

  localparam int TO = 16;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cfg_start = 1'b0, cfg_abort = 1'b0;
  logic [15:0] cfg_len = '0;
  logic        input_buff_empty = 1'b1, output_buff_full = 1'b0;
  logic        core_in_ready = 1'b0, core_out_valid = 1'b0;
  logic        in_rd_en, core_in_valid, core_out_ready, out_wr_en;
  logic        busy, done, err, irq;
  logic [1:0]  err_code;

  accel_job_ctrl #(.CNT_WIDTH(16), .TIMEOUT_CYCLES(TO)) dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
    .cfg_len(cfg_len), .input_buff_empty(input_buff_empty),
    .output_buff_full(output_buff_full), .in_rd_en(in_rd_en),
    .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
    .core_out_valid(core_out_valid), .core_out_ready(core_out_ready),
    .out_wr_en(out_wr_en), .busy(busy), .done(done), .err(err),
    .err_code(err_code), .irq(irq)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0, n_errors = 0;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Job-level model: a job is "open" from an accepted start until both beat
  // counts reach the length; the cycle after it closes is the irq cycle.
  bit m_busy, m_irq, m_done, m_err, m_civ;
  int m_code, m_len, m_in, m_out, m_idle;
  int n_rd, n_wr, n_irq, n_wr_full;

  task automatic model_reset();
    m_busy = 0; m_irq = 0; m_done = 0; m_err = 0; m_civ = 0;
    m_code = 0; m_len = 0; m_in = 0; m_out = 0; m_idle = 0;
  endtask

  task automatic check_all_zero(string tag);
    check_eq({tag, ".in_rd_en"}, in_rd_en, 0);
    check_eq({tag, ".core_in_valid"}, core_in_valid, 0);
    check_eq({tag, ".core_out_ready"}, core_out_ready, 0);
    check_eq({tag, ".out_wr_en"}, out_wr_en, 0);
    check_eq({tag, ".busy"}, busy, 0);
    check_eq({tag, ".done"}, done, 0);
    check_eq({tag, ".err"}, err, 0);
    check_eq({tag, ".err_code"}, err_code, 0);
    check_eq({tag, ".irq"}, irq, 0);
  endtask

  // Entered at negedge+1 with inputs applied; checks, advances model, returns at next negedge+1.
  task automatic cycle();
    bit e_rd, e_ordy, e_wr, nb, ni;
    #1;
    e_rd   = m_busy && !input_buff_empty && core_in_ready && (m_in < m_len);
    e_ordy = m_busy && !output_buff_full && (m_out < m_len);
    e_wr   = e_ordy && core_out_valid;
    check_eq("in_rd_en", in_rd_en, e_rd);
    check_eq("core_in_valid", core_in_valid, m_civ);
    check_eq("core_out_ready", core_out_ready, e_ordy);
    check_eq("out_wr_en", out_wr_en, e_wr);
    check_eq("busy", busy, m_busy);
    check_eq("done", done, m_done);
    check_eq("err", err, m_err);
    check_eq("err_code", err_code, m_code);
    check_eq("irq", irq, m_irq);
    n_rd += int'(in_rd_en);
    n_wr += int'(out_wr_en);
    n_irq += int'(irq);
    if (output_buff_full && out_wr_en) n_wr_full++;

    m_civ = e_rd;
    nb = m_busy;
    ni = 0;
    if (m_busy) begin
      m_in  += int'(e_rd);
      m_out += int'(e_wr);
      if (e_rd || e_wr) m_idle = 0; else m_idle++;
      if (cfg_abort) begin
        nb = 0; ni = 1; m_err = 1; m_code = 2;
      end
`ifdef ACCEL_JOB_CTRL_TIMEOUT_EN
      else if (m_idle >= TO) begin
        nb = 0; ni = 1; m_err = 1; m_code = 3;
      end
`endif
      else if (m_in == m_len && m_out == m_len) begin
        nb = 0; ni = 1; m_done = 1;
      end
    end else if (!m_irq && cfg_start) begin
      m_done = 0; m_err = 0; m_code = 0; m_in = 0; m_out = 0; m_idle = 0;
      if (cfg_len == 0) begin
        m_err = 1; m_code = 1; ni = 1;
      end else begin
        nb = 1; m_len = int'(cfg_len);
      end
    end
    m_busy = nb;
    m_irq = ni;
    @(negedge aclk);
    #1;
  endtask

  // mode 0: inputs as set; 1: random; 2: abort on final write; 3: output full for 5 cycles
  task automatic run_job(int len, int mode, int max_cycles);
    int k;
    n_rd = 0; n_wr = 0; n_irq = 0; n_wr_full = 0;
    cfg_len = 16'(len);
    cfg_start = 1;
    cycle();
    cfg_start = 0;
    k = 0;
    while ((m_busy || m_irq) && k < max_cycles) begin
      if (mode == 1) begin
        input_buff_empty = ($urandom_range(3) == 0);
        core_in_ready    = ($urandom_range(3) != 0);
        core_out_valid   = 1'($urandom_range(1));
        output_buff_full = ($urandom_range(4) == 0);
        cfg_start        = ($urandom_range(15) == 0);
        cfg_len          = 16'($urandom_range(20));
        cfg_abort        = ($urandom_range(63) == 0);
      end else if (mode == 2) begin
        cfg_abort = m_busy && (m_out == m_len - 1) && core_out_valid && !output_buff_full;
      end else if (mode == 3) begin
        output_buff_full = (k >= 2 && k < 7);
      end
      cycle();
      k++;
    end
    cfg_start = 0; cfg_abort = 0; output_buff_full = 0;
    check_eq("job_bound", (k < max_cycles), 1);
    $display("job len=%0d mode=%0d rd=%0d wr=%0d irq=%0d done=%0d err=%0d code=%0d",
             len, mode, n_rd, n_wr, n_irq, done, err, err_code);
  endtask

  task automatic set_flow();
    input_buff_empty = 0; core_in_ready = 1; core_out_valid = 1; output_buff_full = 0;
  endtask

  initial begin
    model_reset();
    #3;
    check_all_zero("reset");
    @(negedge aclk);
    #1;
    aresetn = 1;
    set_flow();
    repeat (2) cycle();

    run_job(4, 0, 50);
    check_eq("basic.rd", n_rd, 4);
    check_eq("basic.wr", n_wr, 4);
    check_eq("basic.irq", n_irq, 1);
    check_eq("basic.done", done, 1);
    check_eq("basic.busy", busy, 0);

    run_job(0, 0, 10);
    check_eq("zero.err", err, 1);
    check_eq("zero.code", err_code, 1);
    check_eq("zero.irq", n_irq, 1);
    check_eq("zero.rd", n_rd, 0);

    run_job(8, 3, 60);
    check_eq("full.wr", n_wr, 8);
    check_eq("full.wr_while_full", n_wr_full, 0);
    check_eq("full.done", done, 1);

    run_job(4, 2, 50);
    check_eq("abort.err", err, 1);
    check_eq("abort.code", err_code, 2);
    check_eq("abort.done", done, 0);

`ifdef ACCEL_JOB_CTRL_TIMEOUT_EN
    input_buff_empty = 1;
    run_job(4, 0, 40);
    check_eq("timeout.code", err_code, 3);
    check_eq("timeout.err", err, 1);
    set_flow();
`endif

    for (int j = 0; j < 25; j++) begin
      run_job(int'($urandom_range(12)) + 1, 1, 600);
      set_flow();
      repeat (2) cycle();
    end

    // Async reset while draining: hold output side off so reads finish first.
    core_out_valid = 0;
    n_irq = 0;
    cfg_len = 16'd4;
    cfg_start = 1;
    cycle();
    cfg_start = 0;
    repeat (6) cycle();
    check_eq("drain.busy", busy, 1);
    core_out_valid = 1;
    #2;
    aresetn = 0;
    #1;
    check_all_zero("async_reset");
    model_reset();
    @(negedge aclk);
    #1;
    aresetn = 1;
    set_flow();
    repeat (3) cycle();
    check_eq("reset.no_irq", n_irq, 0);
    run_job(2, 0, 30);
    check_eq("post_reset.wr", n_wr, 2);
    check_eq("post_reset.done", done, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/accel_job_ctrl.md
ACCEL_JOB_CTRL -- requirements
Module: accel_job_ctrl

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16, width of job length and beat counters.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, stall limit for the watchdog.
REQ-003 SHALL have one clock, aclk; reset aresetn is asynchronous and active-low.
REQ-004 SHALL have ports:
- aclk  in  1  clock
- aresetn  in  1  async active-low reset
- cfg_start  in  1  one-cycle start pulse, decoded from a control-register write
- cfg_abort  in  1  one-cycle abort pulse
- cfg_len  in  CNT_WIDTH  job length in beats
- input_buff_empty  in  1  input buffer empty
- output_buff_full  in  1  output buffer full
- in_rd_en  out  1  pop input buffer
- core_in_valid  out  1  beat presented to core
- core_in_ready  in  1  core accepts input
- core_out_valid  in  1  core result valid
- core_out_ready  out  1  controller accepts result
- out_wr_en  out  1  push output buffer
- busy, done, err  out  1 each  status bits for the memory map
- err_code  out  2  0 none, 1 zero length, 2 abort, 3 timeout
- irq  out  1  completion/error pulse

Function
REQ-005 SHALL implement FSM states IDLE, RUN, DRAIN, DONE, ERR.
REQ-006 IDLE: cfg_start with cfg_len!=0 -> RUN, latch len_q, clear in_cnt/out_cnt, clear done/err/err_code.
REQ-007 IDLE: cfg_start with cfg_len==0 -> ERR, err_code=1.
REQ-008 in_rd_en SHALL be combinational: state RUN && !input_buff_empty && core_in_ready && in_cnt<len_q.
REQ-009 core_in_valid SHALL be in_rd_en delayed one cycle (buffer read latency 1).
REQ-010 in_cnt SHALL increment on in_rd_en; RUN -> DRAIN on the cycle in_cnt reaches len_q.
REQ-011 core_out_ready SHALL be (RUN or DRAIN) && !output_buff_full && out_cnt<len_q.
REQ-012 out_wr_en = core_out_valid && core_out_ready; out_cnt SHALL increment on out_wr_en.
REQ-013 DRAIN -> DONE when out_cnt==len_q; results may be accepted in RUN, and RUN -> DONE directly if both counts complete.
REQ-014 DONE and ERR SHALL each last one cycle, then return to IDLE.
REQ-015 done SHALL set on entry to DONE and err on entry to ERR; both sticky until the next accepted cfg_start.
REQ-016 irq SHALL pulse high for exactly one cycle on entry to DONE or ERR.
REQ-017 busy SHALL be high in RUN and DRAIN only.
REQ-018 cfg_start outside IDLE SHALL be ignored; cfg_len changes after latch SHALL have no effect.
REQ-019 cfg_abort in RUN/DRAIN -> ERR, err_code=2; abort takes priority over same-cycle completion; in IDLE it is ignored.
REQ-020 Counters SHALL never exceed len_q; no wrap is possible.

Reset
REQ-021 On aresetn low: state IDLE, counters and len_q 0, all outputs 0, immediately and independent of aclk.
REQ-022 Reset mid-job SHALL abandon the job with no irq.

Configuration
REQ-023 Macro ACCEL_JOB_CTRL_TIMEOUT_EN SHALL compile in a stall watchdog.
REQ-024 With the macro: a counter clears on any in_rd_en/out_wr_en and increments otherwise in RUN/DRAIN; at TIMEOUT_CYCLES -> ERR, err_code=3.
REQ-025 Without the macro: no watchdog logic; err_code 3 is never produced.

Structure
REQ-026 The state enum, err_code enum and their constants SHALL live in accel_core_pkg.
REQ-027 The watchdog SHALL be sub-module accel_job_wdog, instantiated only under ACCEL_JOB_CTRL_TIMEOUT_EN.

Verification
REQ-028 len=4, buffer non-empty, core always ready -> 4 in_rd_en beats, 4 out_wr_en beats, done=1, one irq pulse, busy low after.
REQ-029 cfg_start with len=0 -> err=1, err_code=1, irq one cycle, no in_rd_en.
REQ-030 len=8, output_buff_full held 5 cycles mid-job -> core_out_ready low for those cycles, no out_wr_en, job completes with 8 writes.
REQ-031 cfg_abort on the same cycle as the final out_wr_en -> ERR, err_code=2, done=0.
REQ-032 With the macro, TIMEOUT_CYCLES=16, input_buff_empty stuck high -> err_code=3 after 16 idle cycles.
REQ-033 aresetn asserted in DRAIN -> all outputs 0 without a clock edge; a following start with len=2 completes normally.
